// File: rtl/led_matrix_driver.sv
// Row-scanned two-colour LED matrix driver with a double-buffered frame store.
// A shadow frame is promoted to the active buffer only in IDLE or at a frame boundary.
module led_matrix_driver #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int DWELL = 1024,
    parameter int BLANK = 8,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] frame_red,
    input  logic [ROWS*COLS-1:0] frame_green,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [ROWS-1:0]      row_en,
    output logic [COLS-1:0]      red_col,
    output logic [COLS-1:0]      green_col,
    output logic [RW-1:0]        row_idx,
    output logic                 frame_start
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_BLANK} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sfull_q, sfull_d;
    logic [ROWS*COLS-1:0]  sh_red_q, sh_red_d, sh_grn_q, sh_grn_d;
    logic [ROWS*COLS-1:0]  act_red_q, act_red_d, act_grn_q, act_grn_d;
    logic [ROWS-1:0]       row_en_q, row_en_d;
    logic [COLS-1:0]       red_col_q, red_col_d, green_col_q, green_col_d;
    logic                  frame_start_q, frame_start_d;
    logic                  accept, promote;

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        cnt_d         = cnt_q;
        promote       = 1'b0;
        frame_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sfull_q) begin
                    promote       = 1'b1;
                    state_d       = ST_DRIVE;
                    row_d         = '0;
                    cnt_d         = CW'(DWELL - 1);
                    frame_start_d = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = ST_BLANK;
                    cnt_d   = CW'(BLANK - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRIVE;
                    cnt_d   = CW'(DWELL - 1);
                    if (row_q == RW'(ROWS - 1)) begin
                        // frame boundary: the only place a new frame may take over mid-display
                        row_d         = '0;
                        frame_start_d = 1'b1;
                        promote       = sfull_q;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // promote needs sfull_q and accept needs ~sfull_q, so they never overlap
        accept    = frame_valid & ~sfull_q;
        sfull_d   = (sfull_q & ~promote) | accept;
        sh_red_d  = accept  ? frame_red   : sh_red_q;
        sh_grn_d  = accept  ? frame_green : sh_grn_q;
        act_red_d = promote ? sh_red_q    : act_red_q;
        act_grn_d = promote ? sh_grn_q    : act_grn_q;

        // outputs are decoded from next state so the registered drive lines up with state_q
        row_en_d    = '0;
        red_col_d   = '0;
        green_col_d = '0;
        if (state_d == ST_DRIVE) begin
            for (int i = 0; i < ROWS; i++) row_en_d[i] = (row_d == RW'(i));
            red_col_d   = act_red_d[row_d*COLS +: COLS];
            green_col_d = act_grn_d[row_d*COLS +: COLS];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            cnt_q         <= '0;
            sfull_q       <= 1'b0;
            sh_red_q      <= '0;
            sh_grn_q      <= '0;
            act_red_q     <= '0;
            act_grn_q     <= '0;
            row_en_q      <= '0;
            red_col_q     <= '0;
            green_col_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            sfull_q       <= sfull_d;
            sh_red_q      <= sh_red_d;
            sh_grn_q      <= sh_grn_d;
            act_red_q     <= act_red_d;
            act_grn_q     <= act_grn_d;
            row_en_q      <= row_en_d;
            red_col_q     <= red_col_d;
            green_col_q   <= green_col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_ready = ~sfull_q;
    assign row_en      = row_en_q;
    assign red_col     = red_col_q;
    assign green_col   = green_col_q;
    assign row_idx     = row_q;
    assign frame_start = frame_start_q;
endmodule
